// File: rtl/fu_result_buffer_pkg.sv
// Shared result-path types for the functional-unit completion buffers.
// The optional same-cycle bypass is enabled with FU_RESULT_BYPASS_EN.
package fu_result_buffer_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ROB    = 32;
    localparam int unsigned NUM_PR = 64;
    localparam int unsigned NUM_FU = 8;

    localparam int unsigned PR_W  = $clog2(NUM_PR);
    localparam int unsigned ROB_W = $clog2(ROB);

    typedef struct packed {
        logic [PR_W-1:0]  dest_pr;
        logic [XLEN-1:0]  dest_value;
        logic [ROB_W-1:0] rob_entry;
        logic             if_take_branch;
        logic [XLEN-1:0]  target_pc;
    } FU_COMPLETE_PACKET;

    // One finish/stall pair per FU slot, exchanged with the complete stage.
    typedef struct packed {
        logic [NUM_FU-1:0] finish;
        logic [NUM_FU-1:0] c_stall;
    } FU_STATE_PACKET;

endpackage

// File: rtl/fu_result_buffer.sv
// Per-FU result FIFO feeding the complete stage; squash flushes it.
// Define FU_RESULT_BYPASS_EN to let an empty buffer offer fu_packet in the same cycle.
module fu_result_buffer
    import fu_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic                         fu_valid,
    input  FU_COMPLETE_PACKET            fu_packet,
    output logic                         fu_ready,
    output logic                         fu_finish,
    input  logic                         fu_c_stall,
    output FU_COMPLETE_PACKET            c_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    FU_COMPLETE_PACKET mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty    = (count_q == '0);
    assign fu_ready = (count_q < FULL_CNT) && !squash;

`ifdef FU_RESULT_BYPASS_EN
    assign bypass = empty && fu_valid && !squash;
`else
    assign bypass = 1'b0;
`endif

    assign fu_finish = !squash && (!empty || bypass);

    // A bypassed result granted this cycle never touches storage.
    assign pop  = fu_finish && !fu_c_stall && !bypass;
    assign push = fu_valid && fu_ready && !(bypass && !fu_c_stall);

    always_comb begin
        c_out = '0;
        if (fu_finish) begin
`ifdef FU_RESULT_BYPASS_EN
            c_out = bypass ? fu_packet : mem[head_q];
`else
            c_out = mem[head_q];
`endif
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
            end
            if (push) begin
                tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; it is only ever read when count is non-zero.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail_q] <= fu_packet;
        end
    end

    assign count = count_q;

endmodule
